rv32e_writeback: RTL and testbench

Writeback stage of the RV32E core, directly upstream of the 16-entry register bank. It accepts completed results from execute: ALU results immediately, loads after the data-memory response. It aligns and sign/zero-extends load data and drives the register bank's write port (write_reg, wreg, write_data). It also exposes pending-load information so decode can stall on load-use hazards, and flags misaligned or timed-out loads.

---
 rtl/rv32e_pkg.sv | 27 ++
 rtl/load_align.sv | 27 ++
 rtl/rv32e_writeback.sv | 114 +++++++++++
 tb/tb_rv32e_writeback.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32e_pkg.sv
// rtl/rv32e_pkg.sv - shared RV32E types: register index, load sizes, writeback states
package rv32e_pkg;

  localparam int REG_W = 4;
  typedef logic [REG_W-1:0] reg_idx_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [0:0] {
    ST_IDLE     = 1'b0,
    ST_WAIT_MEM = 1'b1
  } wb_state_e;

  // Byte loads never fault; the reserved size encoding behaves as a word.
  function automatic logic load_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = addr_lo[0];
      default: bad = (addr_lo != 2'b00);
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - lane select and sign/zero extension of a little-endian load word
module load_align
  import rv32e_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [1:0]  addr_lo,
  output logic [31:0] data
);

  logic [31:0] shifted;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    shifted = rdata >> {addr_lo, 3'b000};
    byte_v  = shifted[7:0];
    half_v  = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      SZ_BYTE: data = {{24{~is_unsigned & byte_v[7]}}, byte_v};
      SZ_HALF: data = {{16{~is_unsigned & half_v[15]}}, half_v};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/rv32e_writeback.sv
// rtl/rv32e_writeback.sv - writeback stage: ALU results, aligned loads, load timeout and faults
module rv32e_writeback
  import rv32e_pkg::*;
#(
  parameter int LOAD_TIMEOUT = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  reg_idx_t    ex_rd,
  input  logic        ex_wreg,
  input  logic        ex_load,
  input  logic [1:0]  ex_size,
  input  logic        ex_unsigned,
  input  logic [1:0]  ex_addr_lo,
  input  logic [31:0] ex_result,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output reg_idx_t    write_reg,
  output logic        wreg,
  output logic [31:0] write_data,
  output logic        load_pending,
  output reg_idx_t    load_rd,
  output logic        misalign_fault,
  output logic        timeout_fault
);

  localparam int CNT_W = $clog2(LOAD_TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOAD_TIMEOUT - 1);

  wb_state_e        state;
  logic [CNT_W-1:0] cnt;
  reg_idx_t         l_rd;
  logic [1:0]       l_size;
  logic             l_unsigned;
  logic [1:0]       l_addr_lo;
  logic             l_wreg;
  logic [31:0]      aligned;

  assign ex_ready     = (state == ST_IDLE);
  assign load_pending = (state == ST_WAIT_MEM);
  assign load_rd      = load_pending ? l_rd : '0;

  load_align u_load_align (
    .rdata       (mem_rdata),
    .size        (l_size),
    .is_unsigned (l_unsigned),
    .addr_lo     (l_addr_lo),
    .data        (aligned)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= ST_IDLE;
      cnt            <= '0;
      l_rd           <= '0;
      l_size         <= SZ_BYTE;
      l_unsigned     <= 1'b0;
      l_addr_lo      <= 2'b00;
      l_wreg         <= 1'b0;
      wreg           <= 1'b0;
      write_reg      <= '0;
      write_data     <= '0;
      misalign_fault <= 1'b0;
      timeout_fault  <= 1'b0;
    end else begin
      wreg           <= 1'b0;
      misalign_fault <= 1'b0;
      timeout_fault  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (ex_valid) begin
            if (!ex_load) begin
              if (ex_wreg && ex_rd != '0) begin
                wreg       <= 1'b1;
                write_reg  <= ex_rd;
                write_data <= ex_result;
              end
            end else if (load_misaligned(ex_size, ex_addr_lo)) begin
              misalign_fault <= 1'b1;
            end else begin
              l_rd       <= ex_rd;
              l_size     <= ex_size;
              l_unsigned <= ex_unsigned;
              l_addr_lo  <= ex_addr_lo;
              l_wreg     <= ex_wreg;
              cnt        <= '0;
              state      <= ST_WAIT_MEM;
            end
          end
        end
        ST_WAIT_MEM: begin
          // Data arriving in the final cycle still beats the timeout.
          if (mem_rvalid) begin
            if (l_wreg && l_rd != '0) begin
              wreg       <= 1'b1;
              write_reg  <= l_rd;
              write_data <= aligned;
            end
            state <= ST_IDLE;
          end else if (cnt == CNT_LAST) begin
            timeout_fault <= 1'b1;
            state         <= ST_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32e_writeback.sv
// tb/tb_rv32e_writeback.sv - scoreboard bench for rv32e_writeback
module tb_rv32e_writeback;

  localparam int LOAD_TIMEOUT = 16;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        ex_valid = 1'b0;
  logic        ex_ready;
  logic [3:0]  ex_rd = '0;
  logic        ex_wreg = 1'b0;
  logic        ex_load = 1'b0;
  logic [1:0]  ex_size = '0;
  logic        ex_unsigned = 1'b0;
  logic [1:0]  ex_addr_lo = '0;
  logic [31:0] ex_result = '0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [3:0]  write_reg;
  logic        wreg;
  logic [31:0] write_data;
  logic        load_pending;
  logic [3:0]  load_rd;
  logic        misalign_fault;
  logic        timeout_fault;

  typedef struct packed {
    logic [3:0]  rd;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  localparam logic [45:0] RESET_VEC = {1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1};

  rv32e_writeback #(.LOAD_TIMEOUT(LOAD_TIMEOUT)) dut (
    .clock          (clock),
    .reset          (reset),
    .ex_valid       (ex_valid),
    .ex_ready       (ex_ready),
    .ex_rd          (ex_rd),
    .ex_wreg        (ex_wreg),
    .ex_load        (ex_load),
    .ex_size        (ex_size),
    .ex_unsigned    (ex_unsigned),
    .ex_addr_lo     (ex_addr_lo),
    .ex_result      (ex_result),
    .mem_rvalid     (mem_rvalid),
    .mem_rdata      (mem_rdata),
    .write_reg      (write_reg),
    .wreg           (wreg),
    .write_data     (write_data),
    .load_pending   (load_pending),
    .load_rd        (load_rd),
    .misalign_fault (misalign_fault),
    .timeout_fault  (timeout_fault)
  );

  always #5 clock = ~clock;

  // Register-bank monitor: every write strobe must match the oldest expected write.
  always @(negedge clock) begin : monitor
    wr_t e;
    if (wreg === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL wb_unexpected: got wreg=1 rd=%0d data=%h, required no write", write_reg, write_data);
      end else begin
        e = exp_q.pop_front();
        if ({write_reg, write_data} !== {e.rd, e.data}) begin
          n_bad++;
          $display("FAIL wb_data: got rd=%0d data=%h, required rd=%0d data=%h",
                   write_reg, write_data, e.rd, e.data);
        end
      end
    end
  end

  task automatic send(input logic [3:0] rd, input logic w, input logic ld, input logic [1:0] sz,
                      input logic un, input logic [1:0] al, input logic [31:0] res);
    ex_valid = 1'b1; ex_rd = rd; ex_wreg = w; ex_load = ld;
    ex_size = sz; ex_unsigned = un; ex_addr_lo = al; ex_result = res;
    if (!ld && w && rd != 4'd0) exp_q.push_back({rd, res});
    @(posedge clock); #1;
    ex_valid = 1'b0; ex_load = 1'b0; ex_wreg = 1'b0; ex_result = $urandom;
  endtask

  task automatic test_reset();
    #2;
    n_cmp++;
    if ({wreg, write_reg, write_data, load_pending, load_rd, misalign_fault, timeout_fault, ex_ready} !== RESET_VEC) begin
      n_bad++;
      $display("FAIL reset_state: got %h, required %h",
               {wreg, write_reg, write_data, load_pending, load_rd, misalign_fault, timeout_fault, ex_ready}, RESET_VEC);
    end
    @(posedge clock); #1 reset = 1'b1;
    @(negedge clock);
    n_cmp++;
    if (ex_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_ready: got %b, required 1", ex_ready);
    end
  endtask

  task automatic test_alu();
    send(4'd5, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 32'hDEADBEEF);
    @(negedge clock);
    n_cmp++;
    if (wreg !== 1'b1) begin
      n_bad++;
      $display("FAIL alu_strobe: got wreg=%b, required 1", wreg);
    end
    @(negedge clock);
    n_cmp++;
    if (wreg !== 1'b0) begin
      n_bad++;
      $display("FAIL alu_one_cycle: got wreg=%b, required 0", wreg);
    end
    send(4'd0, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 32'h12345678);
    send(4'd3, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 32'h87654321);
    repeat (2) @(negedge clock);
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i <= 6; i++) begin
      n_cmp++;
      if (ex_ready !== 1'b1) begin
        n_bad++;
        $display("FAIL b2b_ready: got %b, required 1", ex_ready);
      end
      send(4'(i + 8), 1'b1, 1'b0, 2'b00, 1'b0, 2'b00, $urandom);
    end
    repeat (2) @(negedge clock);
  endtask

  task automatic test_load(input string nm, input logic [3:0] rd, input logic [1:0] sz, input logic un,
                           input logic [1:0] al, input logic [31:0] raw, input logic [31:0] exp, input int wait_n);
    send(rd, 1'b1, 1'b1, sz, un, al, 32'h0);
    for (int i = 0; i < wait_n; i++) begin
      @(negedge clock);
      n_cmp++;
      if ({load_pending, load_rd, ex_ready, misalign_fault, timeout_fault} !== {1'b1, rd, 1'b0, 1'b0, 1'b0}) begin
        n_bad++;
        $display("FAIL %s_pending: got pend=%b rd=%0d ready=%b mis=%b to=%b, required 1 %0d 0 0 0",
                 nm, load_pending, load_rd, ex_ready, misalign_fault, timeout_fault, rd);
      end
      @(posedge clock); #1;
    end
    mem_rvalid = 1'b1; mem_rdata = raw;
    if (rd != 4'd0) exp_q.push_back({rd, exp});
    @(posedge clock); #1;
    mem_rvalid = 1'b0; mem_rdata = $urandom;
    @(negedge clock);
    n_cmp++;
    if ({load_pending, ex_ready, timeout_fault} !== 3'b010) begin
      n_bad++;
      $display("FAIL %s_done: got pend=%b ready=%b to=%b, required 0 1 0", nm, load_pending, ex_ready, timeout_fault);
    end
  endtask

  task automatic test_loads();
    test_load("lb",  4'd7,  2'b00, 1'b0, 2'd3, 32'h80123456, 32'hFFFFFF80, 4);
    test_load("lhu", 4'd2,  2'b01, 1'b1, 2'd2, 32'h80123456, 32'h00008012, 1);
    test_load("lh",  4'd11, 2'b01, 1'b0, 2'd2, 32'h80123456, 32'hFFFF8012, 0);
    test_load("lbu", 4'd6,  2'b00, 1'b1, 2'd1, 32'h80123456, 32'h00000034, 2);
    test_load("lbs", 4'd8,  2'b00, 1'b0, 2'd1, 32'h1234F6AB, 32'hFFFFFFF6, 1);
    test_load("lw",  4'd9,  2'b10, 1'b0, 2'd0, 32'hCAFEF00D, 32'hCAFEF00D, 3);
    test_load("lw0", 4'd0,  2'b10, 1'b0, 2'd0, 32'h11112222, 32'h11112222, 2);
    // Load result followed immediately by an ALU op accepted in the write cycle.
    test_load("lr",  4'd12, 2'b11, 1'b0, 2'd0, 32'h0BADCAFE, 32'h0BADCAFE, 1);
    n_cmp++;
    if (ex_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL load_then_alu_ready: got %b, required 1", ex_ready);
    end
    send(4'd13, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 32'h5A5AA5A5);
    repeat (2) @(negedge clock);
  endtask

  task automatic test_misalign();
    logic [1:0] sz_t [3] = '{2'b10, 2'b01, 2'b10};
    logic [1:0] al_t [3] = '{2'd1, 2'd3, 2'd2};
    for (int i = 0; i < 3; i++) begin
      send(4'd6, 1'b1, 1'b1, sz_t[i], 1'b0, al_t[i], 32'h0);
      @(negedge clock);
      n_cmp++;
      if ({misalign_fault, ex_ready, load_pending} !== 3'b110) begin
        n_bad++;
        $display("FAIL misalign_%0d: got mis=%b ready=%b pend=%b, required 1 1 0",
                 i, misalign_fault, ex_ready, load_pending);
      end
      @(negedge clock);
      n_cmp++;
      if (misalign_fault !== 1'b0) begin
        n_bad++;
        $display("FAIL misalign_pulse_%0d: got %b, required 0", i, misalign_fault);
      end
    end
  endtask

  task automatic test_timeout();
    int k;
    send(4'd3, 1'b1, 1'b1, 2'b10, 1'b0, 2'd0, 32'h0);
    k = 0;
    forever begin
      @(negedge clock);
      if (timeout_fault === 1'b1 || k > 3 * LOAD_TIMEOUT) break;
      k++;
    end
    n_cmp++;
    if (k !== LOAD_TIMEOUT) begin
      n_bad++;
      $display("FAIL timeout_latency: got %0d cycles, required %0d", k, LOAD_TIMEOUT);
    end
    n_cmp++;
    if ({load_pending, ex_ready} !== 2'b01) begin
      n_bad++;
      $display("FAIL timeout_idle: got pend=%b ready=%b, required 0 1", load_pending, ex_ready);
    end
    @(negedge clock);
    n_cmp++;
    if (timeout_fault !== 1'b0) begin
      n_bad++;
      $display("FAIL timeout_pulse: got %b, required 0", timeout_fault);
    end
    // rvalid in the last allowed cycle: data wins, no fault.
    send(4'd4, 1'b1, 1'b1, 2'b10, 1'b0, 2'd0, 32'h0);
    repeat (LOAD_TIMEOUT - 1) begin @(posedge clock); #1; end
    mem_rvalid = 1'b1; mem_rdata = 32'h600DDA7A;
    exp_q.push_back({4'd4, 32'h600DDA7A});
    @(posedge clock); #1;
    mem_rvalid = 1'b0;
    @(negedge clock);
    n_cmp++;
    if ({timeout_fault, wreg, load_pending} !== 3'b010) begin
      n_bad++;
      $display("FAIL late_rvalid: got to=%b wreg=%b pend=%b, required 0 1 0", timeout_fault, wreg, load_pending);
    end
    @(negedge clock);
  endtask

  task automatic test_reset_mid_load();
    send(4'd10, 1'b1, 1'b1, 2'b10, 1'b0, 2'd0, 32'h0);
    repeat (3) begin @(posedge clock); #1; end
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({wreg, write_reg, write_data, load_pending, load_rd, misalign_fault, timeout_fault, ex_ready} !== RESET_VEC) begin
      n_bad++;
      $display("FAIL midload_reset: got %h, required %h",
               {wreg, write_reg, write_data, load_pending, load_rd, misalign_fault, timeout_fault, ex_ready}, RESET_VEC);
    end
    @(posedge clock); #1;
    reset = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'hBAADF00D;
    @(posedge clock); #1;
    mem_rvalid = 1'b0;
    @(negedge clock);
    n_cmp++;
    if ({wreg, write_reg, write_data, load_pending, load_rd, misalign_fault, timeout_fault, ex_ready} !== RESET_VEC) begin
      n_bad++;
      $display("FAIL midload_release: got %h, required %h",
               {wreg, write_reg, write_data, load_pending, load_rd, misalign_fault, timeout_fault, ex_ready}, RESET_VEC);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_back_to_back();
    test_loads();
    test_misalign();
    test_timeout();
    test_reset_mid_load();
    repeat (3) @(negedge clock);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL missing_writes: got %0d writes outstanding, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, required finish");
    $fatal(1);
  end

endmodule
